// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one multi-cycle main memory between the I-cache and D-cache fill
//   FSMs. One requester owns memory at a time; its address stream is
//   forwarded and returning read data is flagged to the owner only.
//   Ownership is held until every outstanding read has come back.
//   D-cache write-through stores are slotted in as single-cycle accesses
//   between fills.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> simultaneous fill requests alternate
//                                    (last-owner register, reset = D)
//                       undefined -> fixed priority, D-cache over I-cache
//   Stores always beat fills.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_req/i_addr, d_req/d_addr      fill requests (level) and fill addresses
//   i_grant, d_grant                ownership indication per cache
//   i_data_valid, d_data_valid      mem_valid routed to the owner
//   d_wr_req/d_wr_addr/d_wr_data    store request, held until d_wr_ack
//   d_wr_ack                        one-cycle pulse when the store is issued
//   mem_addr/mem_enable/mem_wr/
//   mem_wdata                       memory command
//   mem_valid/mem_rdata             memory read return
//   rdata                           mem_rdata passed straight through
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_data_valid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_grant,
    output logic              d_data_valid,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_OWN_I,
        ST_OWN_D,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_I,
        OWNER_D
    } owner_t;

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] cnt_next;
    logic             issue;
    logic             ret;
    logic             pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t           last_owner;
`endif

    assign rdata = mem_rdata;

    // Owner-side IDLE choice between fill requests (stores handled first in the FSM).
    always_comb begin
        pick_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req)
            pick_d = (last_owner != OWNER_D);
`endif
    end

    always_comb begin
        i_grant      = (state == ST_OWN_I) || (state == ST_DRAIN && owner == OWNER_I);
        d_grant      = (state == ST_OWN_D) || (state == ST_DRAIN && owner == OWNER_D);
        issue        = (state == ST_OWN_I && i_req) || (state == ST_OWN_D && d_req);
        // A return nobody is waiting for is dropped rather than routed.
        ret          = mem_valid && (owner != OWNER_NONE) && (outstanding != '0);
        i_data_valid = ret && (owner == OWNER_I);
        d_data_valid = ret && (owner == OWNER_D);
        d_wr_ack     = (state == ST_WRITE);
        mem_enable   = d_wr_ack || issue;
        mem_wr       = d_wr_ack;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state)
            ST_WRITE: begin
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
            end
            ST_OWN_I: mem_addr = i_addr;
            ST_OWN_D: mem_addr = d_addr;
            default: ;
        endcase

        cnt_next = outstanding;
        if (issue && !ret) begin
            if (outstanding != '1)
                cnt_next = outstanding + CNT_W'(1);
        end else if (!issue && ret) begin
            cnt_next = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= OWNER_NONE;
            outstanding <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner  <= OWNER_D;
`endif
        end else begin
            outstanding <= cnt_next;
            case (state)
                ST_IDLE: begin
                    if (d_wr_req) begin
                        state <= ST_WRITE;
                    end else if (pick_d) begin
                        state <= ST_OWN_D;
                        owner <= OWNER_D;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= OWNER_D;
`endif
                    end else if (i_req) begin
                        state <= ST_OWN_I;
                        owner <= OWNER_I;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= OWNER_I;
`endif
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                ST_OWN_I: if (!i_req) state <= ST_DRAIN;
                ST_OWN_D: if (!d_req) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (cnt_next == '0) begin
                        state <= ST_IDLE;
                        owner <= OWNER_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWNER_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed stimulus, a reference model of
// ownership/outstanding reads checked every cycle, a latency-4 memory, and
// literal expectations at the key points of each scenario.
module tb_cache_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LAT     = 4;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_grant;
    logic              i_data_valid;
    logic              d_req = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic              d_grant;
    logic              d_data_valid;
    logic              d_wr_req = 1'b0;
    logic [ADDR_W-1:0] d_wr_addr = '0;
    logic [DATA_W-1:0] d_wr_data = '0;
    logic              d_wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_enable;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_valid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] rdata;

    cache_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_grant     (i_grant),
        .i_data_valid(i_data_valid),
        .d_req       (d_req),
        .d_addr      (d_addr),
        .d_grant     (d_grant),
        .d_data_valid(d_data_valid),
        .d_wr_req    (d_wr_req),
        .d_wr_addr   (d_wr_addr),
        .d_wr_data   (d_wr_data),
        .d_wr_ack    (d_wr_ack),
        .mem_addr    (mem_addr),
        .mem_enable  (mem_enable),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .rdata       (rdata)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Observed event counters (from DUT outputs), cleared per scenario.
    int n_reads = 0;
    int n_idv   = 0;
    int n_ddv   = 0;
    int n_wr_in_fill = 0;

    bit inject = 1'b0;
    bit pipe [LAT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: who owns memory, whether that owner has stopped
    // requesting, whether a store slot is active, and reads in flight.
    int m_owner = 0;   // 0 none, 1 I, 2 D
    bit m_drain = 0;
    bit m_write = 0;
    int m_out   = 0;
    int m_last  = 2;

    initial begin
        for (int i = 0; i < LAT; i++) pipe[i] = 1'b0;
        forever begin
            bit        req_o, fill_phase, issuing, ret;
            logic [15:0] addr_o, e_addr, e_wd;
            @(negedge clk);
            if (!rst_n) begin
                m_owner = 0; m_drain = 0; m_write = 0; m_out = 0; m_last = 2;
            end
            req_o      = (m_owner == 1) ? i_req : (m_owner == 2) ? d_req : 1'b0;
            addr_o     = (m_owner == 1) ? i_addr : (m_owner == 2) ? d_addr : 16'h0;
            fill_phase = (m_owner != 0) && !m_drain;
            issuing    = fill_phase && req_o;
            ret        = mem_valid && (m_owner != 0) && (m_out > 0);
            e_addr     = m_write ? d_wr_addr : (fill_phase ? addr_o : 16'h0);
            e_wd       = m_write ? d_wr_data : 16'h0;

            check("i_grant",      i_grant,      m_owner == 1);
            check("d_grant",      d_grant,      m_owner == 2);
            check("i_data_valid", i_data_valid, ret && m_owner == 1);
            check("d_data_valid", d_data_valid, ret && m_owner == 2);
            check("d_wr_ack",     d_wr_ack,     m_write);
            check("mem_enable",   mem_enable,   m_write || issuing);
            check("mem_wr",       mem_wr,       m_write);
            check("mem_addr",     mem_addr,     e_addr);
            check("mem_wdata",    mem_wdata,    e_wd);
            check("rdata",        rdata,        mem_rdata);

            if (mem_enable && !mem_wr) n_reads++;
            if (i_data_valid) n_idv++;
            if (d_data_valid) n_ddv++;
            if (mem_wr && (i_grant || d_grant)) n_wr_in_fill++;

            for (int i = 0; i < LAT - 1; i++) pipe[i] = pipe[i+1];
            pipe[LAT-1] = mem_enable && !mem_wr;

            if (rst_n) begin
                if (issuing && !ret) begin
                    if (m_out < CNT_MAX) m_out++;
                end else if (!issuing && ret) begin
                    m_out--;
                end
                if (m_write) begin
                    m_write = 0;
                end else if (m_owner == 0) begin
                    if (d_wr_req) m_write = 1;
                    else if (i_req && d_req) begin
                        m_owner = RR ? ((m_last == 2) ? 1 : 2) : 2;
                        m_last  = m_owner;
                    end else if (d_req) begin
                        m_owner = 2; m_last = 2;
                    end else if (i_req) begin
                        m_owner = 1; m_last = 1;
                    end
                end else if (!m_drain) begin
                    if (!req_o) m_drain = 1;
                end else if (m_out == 0) begin
                    m_owner = 0; m_drain = 0;
                end
            end
        end
    end

    // Memory return driver: latency-LAT reads plus stray injected pulses.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_valid = pipe[0] | inject;
            mem_rdata = DATA_W'($urandom);
        end
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #1; endtask

    task automatic clear_stats();
        n_reads = 0; n_idv = 0; n_ddv = 0; n_wr_in_fill = 0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            mid();
            if (!i_grant && !d_grant) begin ok = 1'b1; break; end
        end
        check(name, ok, 1'b1);
    endtask

    initial begin
        bit ok;
        #1 rst_n = 1'b0;
        repeat (3) cyc();
        mid();
        check("rst_i_grant",    i_grant,    1'b0);
        check("rst_d_grant",    d_grant,    1'b0);
        check("rst_mem_enable", mem_enable, 1'b0);
        check("rst_mem_addr",   mem_addr,   16'h0);
        check("rst_d_wr_ack",   d_wr_ack,   1'b0);
        cyc(); rst_n = 1'b1;
        cyc();

        // 1: I fill of 8 words, latency 4.
        cyc(); clear_stats(); i_req = 1'b1; i_addr = 16'h0100;
        mid(); check("t1_grant_latency", i_grant, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(); i_addr = 16'h0100 + 16'(2 * k);
            mid();
            if (k == 0) begin
                check("t1_granted",    i_grant,  1'b1);
                check("t1_first_addr", mem_addr, 16'h0100);
            end
        end
        cyc(); i_req = 1'b0; i_addr = '0;
        wait_idle("t1_release");
        check("t1_reads",  n_reads, 8);
        check("t1_i_dv",   n_idv,   8);
        check("t1_d_dv",   n_ddv,   0);

        // 2a: short D fill so D is the last owner.
        cyc(); d_req = 1'b1; d_addr = 16'h0400;
        mid();
        cyc(); mid();
        cyc(); d_addr = 16'h0402; mid();
        cyc(); d_req = 1'b0;
        wait_idle("t2a_release");

        // 2b: simultaneous requests.
        cyc(); i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0600; d_addr = 16'h0800;
        mid();
        check("t2_no_grant_idle", i_grant | d_grant, 1'b0);
        cyc(); mid();
        check("t2_i_grant", i_grant, RR);
        check("t2_d_grant", d_grant, !RR);
        cyc(); mid();
        cyc(); if (RR) i_req = 1'b0; else d_req = 1'b0;
        mid(); check("t2_loser_waits", RR ? d_grant : i_grant, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            mid();
            if (RR ? d_grant : i_grant) begin ok = 1'b1; break; end
        end
        check("t2_loser_granted", ok, 1'b1);
        check("t2_winner_released", RR ? i_grant : d_grant, 1'b0);
        cyc(); i_req = 1'b0; d_req = 1'b0;
        wait_idle("t2b_release");

        // 3: store arrives during an I fill.
        cyc(); clear_stats(); i_req = 1'b1; i_addr = 16'h0A00;
        mid(); cyc(); mid();
        cyc(); d_wr_req = 1'b1; d_wr_addr = 16'h2000; d_wr_data = 16'hBEEF;
        mid();
        check("t3_no_ack_in_fill", d_wr_ack, 1'b0);
        check("t3_no_wr_in_fill",  mem_wr,   1'b0);
        repeat (3) begin cyc(); mid(); end
        cyc(); i_req = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            mid();
            if (d_wr_ack) begin ok = 1'b1; break; end
        end
        check("t3_ack_seen",  ok,        1'b1);
        check("t3_mem_wr",    mem_wr,    1'b1);
        check("t3_mem_addr",  mem_addr,  16'h2000);
        check("t3_mem_wdata", mem_wdata, 16'hBEEF);
        check("t3_no_grant",  i_grant,   1'b0);
        cyc(); d_wr_req = 1'b0;
        mid(); check("t3_ack_pulse", d_wr_ack, 1'b0);
        check("t3_wr_during_fill", n_wr_in_fill, 0);

        // 4: D drops req with 3 reads in flight.
        cyc(); clear_stats(); d_req = 1'b1; d_addr = 16'h0C00;
        mid();
        for (int k = 0; k < 3; k++) begin
            cyc(); d_addr = 16'h0C00 + 16'(2 * k); mid();
        end
        cyc(); d_req = 1'b0;
        mid();
        check("t4_no_issue", mem_enable, 1'b0);
        check("t4_hold",     d_grant,    1'b1);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            mid();
            if (n_ddv == 3) begin ok = 1'b1; break; end
        end
        check("t4_third_valid", ok, 1'b1);
        check("t4_grant_at_last", d_grant, 1'b1);
        mid();
        check("t4_idle_after_last", d_grant, 1'b0);

        // 5: stray return while idle.
        cyc(); clear_stats(); inject = 1'b1;
        mid();
        check("t5_i_dv", i_data_valid, 1'b0);
        check("t5_d_dv", d_data_valid, 1'b0);
        cyc(); inject = 1'b0; i_req = 1'b1; i_addr = 16'h0300;
        mid(); cyc(); mid();
        cyc(); i_req = 1'b0;
        wait_idle("t5_release");
        check("t5_reads", n_reads, 1);
        check("t5_i_dv_count", n_idv, 1);

        // 6: reset mid-fill with 2 reads outstanding.
        cyc(); clear_stats(); i_req = 1'b1; i_addr = 16'h0E00;
        mid(); cyc(); mid(); cyc(); mid();
        cyc(); #2 rst_n = 1'b0;
        #1;
        check("t6_async_grant",  i_grant,    1'b0);
        check("t6_async_enable", mem_enable, 1'b0);
        check("t6_async_addr",   mem_addr,   16'h0);
        i_req = 1'b0;
        repeat (4) begin
            cyc(); mid();
            check("t6_no_i_dv_in_reset", i_data_valid, 1'b0);
        end
        cyc(); rst_n = 1'b1;
        cyc(); inject = 1'b1;
        mid();
        check("t6_late_i_dv", i_data_valid, 1'b0);
        check("t6_late_d_dv", d_data_valid, 1'b0);
        cyc(); inject = 1'b0;
        check("t6_i_dv_total", n_idv, 0);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
